// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite responder for a 4 x 32-bit control register bank.
// It exports the register contents and a one-cycle write pulse per register to the datapath.
module axi_lite_reg_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    output logic [3:0]                        wr_pulse_o
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];

    logic                          r_awready;
    logic                          r_wready;
    logic                          r_aw_lat;
    logic                          r_w_lat;
    logic [1:0]                    r_awaddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]             r_wstrb;
    logic                          r_bvalid;
    logic [3:0]                    r_wr_pulse;

    logic                          r_arready;
    logic                          r_ar_pend;
    logic [1:0]                    r_araddr;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_commit;
    logic w_aw_lat_n;
    logic w_w_lat_n;
    logic w_bvalid_n;
    logic w_ar_pend_n;
    logic w_rvalid_n;
    logic w_unused;

    function automatic logic [C_S_AXI_DATA_WIDTH-1:0] byte_merge(
        input logic [C_S_AXI_DATA_WIDTH-1:0] old_val,
        input logic [C_S_AXI_DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]             strb
    );
        logic [C_S_AXI_DATA_WIDTH-1:0] m;
        m = old_val;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                m[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return m;
    endfunction

    assign w_aw_hs  = r_awready & S_AXI_AWVALID;
    assign w_w_hs   = r_wready & S_AXI_WVALID;
    assign w_b_hs   = r_bvalid & S_AXI_BREADY;
    assign w_ar_hs  = r_arready & S_AXI_ARVALID;
    assign w_r_hs   = r_rvalid & S_AXI_RREADY;
    assign w_commit = r_aw_lat & r_w_lat & ~r_bvalid;

    // Ready flags are registered from next-state so no input reaches an output combinationally.
    assign w_aw_lat_n  = (r_aw_lat | w_aw_hs) & ~w_b_hs;
    assign w_w_lat_n   = (r_w_lat | w_w_hs) & ~w_b_hs;
    assign w_bvalid_n  = w_commit | (r_bvalid & ~S_AXI_BREADY);
    assign w_ar_pend_n = w_ar_hs;
    assign w_rvalid_n  = r_ar_pend | (r_rvalid & ~S_AXI_RREADY);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_lat   <= 1'b0;
            r_w_lat    <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_wr_pulse <= '0;
            r_arready  <= 1'b0;
            r_ar_pend  <= 1'b0;
            r_araddr   <= '0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_aw_hs) begin
                r_aw_lat <= 1'b1;
                r_awaddr <= S_AXI_AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_w_lat <= 1'b1;
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end

            r_wr_pulse <= '0;
            if (w_commit) begin
                r_regs[r_awaddr]     <= byte_merge(r_regs[r_awaddr], r_wdata, r_wstrb);
                r_wr_pulse[r_awaddr] <= 1'b1;
                r_bvalid             <= 1'b1;
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
                r_aw_lat <= 1'b0;
                r_w_lat  <= 1'b0;
            end

            r_awready <= ~w_aw_lat_n & ~w_bvalid_n;
            r_wready  <= ~w_w_lat_n & ~w_bvalid_n;

            // Read data is sampled one cycle after AR, before any same-edge write commit lands.
            if (w_ar_hs) begin
                r_ar_pend <= 1'b1;
                r_araddr  <= S_AXI_ARADDR[3:2];
            end
            if (r_ar_pend) begin
                r_ar_pend <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= r_regs[r_araddr];
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end

            r_arready <= ~w_ar_pend_n & ~w_rvalid_n;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_rvalid;
    assign reg0_o        = r_regs[0];
    assign reg1_o        = r_regs[1];
    assign reg2_o        = r_regs[2];
    assign reg3_o        = r_regs[3];
    assign wr_pulse_o    = r_wr_pulse;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Directed bench for axi_lite_reg_responder: tasks drive the channels and queue expectations,
// monitor processes pop and compare whenever B, R or a write pulse appears.
module tb_axi_lite_reg_responder;

    logic        clk;
    logic        rstn;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  wr_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]  qb[$];
    logic [33:0] qr[$];
    logic [35:0] qp[$];

    axi_lite_reg_responder #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .reg0_o       (reg0),
        .reg1_o       (reg1),
        .reg2_o       (reg2),
        .reg3_o       (reg3),
        .wr_pulse_o   (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual event missing or unexpected, required per scoreboard", name);
    endtask

    function automatic logic [31:0] reg_by_mask(input logic [3:0] m);
        case (m)
            4'b0001: return reg0;
            4'b0010: return reg1;
            4'b0100: return reg2;
            4'b1000: return reg3;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (qb.size() == 0) note_fail("b_unexpected");
            else chk("bresp", {34'b0, bresp}, {34'b0, qb.pop_front()});
        end
    end

    always @(negedge clk) begin
        logic [33:0] e;
        if (rvalid === 1'b1 && rready === 1'b1) begin
            if (qr.size() == 0) note_fail("r_unexpected");
            else begin
                e = qr.pop_front();
                chk("rdata", {4'b0, rdata}, {4'b0, e[31:0]});
                chk("rresp", {34'b0, rresp}, {34'b0, e[33:32]});
            end
        end
    end

    always @(negedge clk) begin
        logic [35:0] e;
        if ((|wr_pulse) === 1'b1) begin
            if (qp.size() == 0) note_fail("wr_pulse_unexpected");
            else begin
                e = qp.pop_front();
                chk("wr_pulse", {32'b0, wr_pulse}, {32'b0, e[35:32]});
                chk("reg_on_pulse", {4'b0, reg_by_mask(e[35:32])}, {4'b0, e[31:0]});
            end
        end
    end

    task automatic wait_ready(input int ch);
        int  n;
        logic rdy;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (ch == 0) ? awready : (ch == 1) ? wready : arready;
            if (rdy === 1'b1) break;
            n++;
            if (n > 60) begin
                note_fail("handshake_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            input logic [3:0] pmask, input logic [31:0] preg);
        qb.push_back(2'b00);
        qp.push_back({pmask, preg});
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1;
                awaddr  = addr;
                awvalid = 1'b1;
                wait_ready(0);
                awvalid = 1'b0;
            end
            begin
                repeat (w_dly) @(posedge clk);
                #1;
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
                wait_ready(1);
                wvalid = 1'b0;
            end
        join
    endtask

    // BVALID must stay low until the AW handshake, stay low one more cycle, then rise.
    task automatic watch_b(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (awvalid === 1'b1 && awready === 1'b1) break;
            chk({name, "_no_bvalid_early"}, {35'b0, bvalid}, 36'd0);
            n++;
            if (n > 60) begin
                note_fail({name, "_aw_timeout"});
                return;
            end
        end
        @(negedge clk);
        chk({name, "_bvalid_k"}, {35'b0, bvalid}, 36'd0);
        @(negedge clk);
        chk({name, "_bvalid_k1"}, {35'b0, bvalid}, 36'd1);
    endtask

    task automatic wr_chk(input string name, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [3:0] pmask, input logic [31:0] preg);
        fork
            do_write(addr, data, strb, aw_dly, w_dly, pmask, preg);
            watch_b(name);
        join
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
        qr.push_back({2'b00, exp});
        araddr  = addr;
        arvalid = 1'b1;
        wait_ready(2);
        arvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((qb.size() + qr.size() + qp.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 36'(qb.size() + qr.size() + qp.size()), 36'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_readies"}, {33'b0, awready, wready, arready}, 36'd0);
        chk({name, "_valids"}, {34'b0, bvalid, rvalid}, 36'd0);
        chk({name, "_resp"}, {32'b0, bresp, rresp}, 36'd0);
        chk({name, "_rdata"}, {4'b0, rdata}, 36'd0);
        chk({name, "_regs"}, {4'b0, reg0 | reg1 | reg2 | reg3}, 36'd0);
        chk({name, "_wr_pulse"}, {32'b0, wr_pulse}, 36'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn    = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        // T1: reset state, then readies one cycle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("t1_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_readies_up", {33'b0, awready, wready, arready}, 36'h7);
        chk("t1_regs_zero", {4'b0, reg0 | reg1 | reg2 | reg3}, 36'd0);
        @(posedge clk);
        #1;

        // T2: concurrent AW+W to each register, then read back (plus an aliased address)
        wr_chk("t2_w0", 4'h0, 32'h0101FFFF, 4'hF, 0, 0, 4'b0001, 32'h0101FFFF);
        drain("t2_w0");
        wr_chk("t2_w1", 4'h4, 32'hABCD0001, 4'hF, 0, 0, 4'b0010, 32'hABCD0001);
        drain("t2_w1");
        wr_chk("t2_w2", 4'h8, 32'hDEAD0011, 4'hF, 0, 0, 4'b0100, 32'hDEAD0011);
        drain("t2_w2");
        wr_chk("t2_w3", 4'hC, 32'hBEEF0011, 4'hF, 0, 0, 4'b1000, 32'hBEEF0011);
        drain("t2_w3");
        do_read(4'h0, 32'h0101FFFF);
        drain("t2_r0");
        do_read(4'h4, 32'hABCD0001);
        drain("t2_r1");
        do_read(4'h8, 32'hDEAD0011);
        drain("t2_r2");
        do_read(4'hC, 32'hBEEF0011);
        drain("t2_r3");
        do_read(4'h5, 32'hABCD0001);
        drain("t2_alias");

        // T3: W first, AW three cycles later
        wr_chk("t3", 4'h4, 32'h12345678, 4'hF, 3, 0, 4'b0010, 32'h12345678);
        drain("t3");
        chk("t3_reg1", {4'b0, reg1}, {4'b0, 32'h12345678});

        // T4: partial byte strobes
        wr_chk("t4", 4'h8, 32'hAABBCCDD, 4'b0101, 0, 0, 4'b0100, 32'hDEBB00DD);
        drain("t4");
        do_read(4'h8, 32'hDEBB00DD);
        drain("t4_rd");

        // T5: back-pressure on B and R; a second write must wait for the B handshake
        bready = 1'b0;
        rready = 1'b0;
        do_write(4'h0, 32'h00000005, 4'hF, 0, 0, 4'b0001, 32'h00000005);
        do_read(4'h4, 32'h12345678);
        fork
            do_write(4'hC, 32'h00000077, 4'hF, 0, 0, 4'b1000, 32'h00000077);
        join_none
        begin
            int n;
            n = 0;
            while (!(bvalid === 1'b1 && rvalid === 1'b1) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t5_both_valid", {34'b0, bvalid, rvalid}, 36'h3);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valids", {34'b0, bvalid, rvalid}, 36'h3);
            chk("t5_hold_bresp", {34'b0, bresp}, 36'd0);
            chk("t5_hold_rdata", {4'b0, rdata}, {4'b0, 32'h12345678});
            chk("t5_hold_readies", {33'b0, awready, wready, arready}, 36'd0);
            chk("t5_reg3_untouched", {4'b0, reg3}, {4'b0, 32'hBEEF0011});
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        rready = 1'b1;
        wait fork;
        drain("t5");
        do_read(4'hC, 32'h00000077);
        drain("t5_rd3");
        do_read(4'h0, 32'h00000005);
        drain("t5_rd0");

        // T6: reset while AW is latched but W never arrived
        awaddr  = 4'h8;
        awvalid = 1'b1;
        wait_ready(0);
        awvalid = 1'b0;
        rstn    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("t6_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        wr_chk("t6", 4'hC, 32'hCAFEF00D, 4'hF, 2, 0, 4'b1000, 32'hCAFEF00D);
        drain("t6");
        chk("t6_reg3", {4'b0, reg3}, {4'b0, 32'hCAFEF00D});
        do_read(4'h8, 32'h00000000);
        drain("t6_rd2");
        do_read(4'hF, 32'hCAFEF00D);
        drain("t6_alias");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
